// File: rtl/mips_mc_control.sv
// mips_mc_control
//   Multicycle control FSM for the MIPS core. It decodes the instruction
//   register opcode into the datapath mux selects and write enables. Every
//   memory state (FETCH, MEMRD, MEMWR) waits on a ready handshake, and a
//   bounded wait counter sends the FSM to a sticky FAULT state on timeout.
//   The FSM supports R-type, lw, sw, beq, bne, j and addi.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   opcode[5:0]     instruction_register[31:26]
//   mem_ready       memory finishes the current access this cycle
//   pc_write, pc_write_cond, pc_write_ncond, iord, mem_read, mem_write,
//   ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
//   alu_src_b[1:0], alu_op[1:0], pc_source[1:0]   datapath strobes/selects
//   fault           sticky timeout / illegal-opcode flag
//   state[3:0]      current FSM state (debug)
module mips_mc_control #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_LIMIT    = 15,
  parameter int WAIT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_ncond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_FAULT  = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                bne_q, bne_d;     // branch flavour latched in DECODE
  logic                fault_q, fault_d;

  logic rdy;
  logic timeout;

  // Without the handshake, every memory access completes in one cycle.
  assign rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign timeout = !rdy && (wait_cnt_q == WAIT_W'(WAIT_LIMIT));

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;                 // any exit or ready cycle clears it
    bne_d          = bne_q;
    fault_d        = fault_q;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    pc_write_ncond = 1'b0;
    iord           = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    alu_op         = 2'b00;
    pc_source      = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // ir_write/pc_write only in the ready cycle: one pulse per fetch
        if (rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        bne_d     = (opcode == OP_BNE);
        case (opcode)
          OP_R:           state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default:        state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FAULT;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (rdy)          state_d = S_MEMWB;
        else if (timeout) state_d = S_FAULT;
        else              wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (rdy)          state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
        else              wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a      = 1'b1;
        alu_op         = 2'b01;
        pc_source      = 2'b01;
        pc_write_cond  = !bne_q;
        pc_write_ncond = bne_q;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;       // unused encodings 13..15
    endcase

    if (state_d == S_FAULT) fault_d = 1'b1;

    // No strobe may reach the datapath during a reset cycle.
    if (rst) begin
      pc_write       = 1'b0;
      pc_write_cond  = 1'b0;
      pc_write_ncond = 1'b0;
      iord           = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      ir_write       = 1'b0;
      mem_to_reg     = 1'b0;
      reg_write      = 1'b0;
      reg_dst        = 1'b0;
      alu_src_a      = 1'b0;
      alu_src_b      = 2'b00;
      alu_op         = 2'b00;
      pc_source      = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      bne_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bne_q      <= bne_d;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       mem_ready_nh = 1'b0;

  logic       h_pw, h_pwc, h_pwn, h_iord, h_mr, h_mw, h_irw, h_m2r, h_rw, h_rd, h_sa;
  logic [1:0] h_sb, h_op, h_ps;
  logic       h_fault;
  logic [3:0] h_state;
  logic       n_pw, n_pwc, n_pwn, n_iord, n_mr, n_mw, n_irw, n_m2r, n_rw, n_rd, n_sa;
  logic [1:0] n_sb, n_op, n_ps;
  logic       n_fault;
  logic [3:0] n_state;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mips_mc_control u_hs (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(h_pw), .pc_write_cond(h_pwc), .pc_write_ncond(h_pwn), .iord(h_iord),
    .mem_read(h_mr), .mem_write(h_mw), .ir_write(h_irw), .mem_to_reg(h_m2r),
    .reg_write(h_rw), .reg_dst(h_rd), .alu_src_a(h_sa), .alu_src_b(h_sb),
    .alu_op(h_op), .pc_source(h_ps), .fault(h_fault), .state(h_state)
  );

  mips_mc_control #(.MEM_HANDSHAKE(1'b0)) u_nh (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready_nh),
    .pc_write(n_pw), .pc_write_cond(n_pwc), .pc_write_ncond(n_pwn), .iord(n_iord),
    .mem_read(n_mr), .mem_write(n_mw), .ir_write(n_irw), .mem_to_reg(n_m2r),
    .reg_write(n_rw), .reg_dst(n_rd), .alu_src_a(n_sa), .alu_src_b(n_sb),
    .alu_op(n_op), .pc_source(n_ps), .fault(n_fault), .state(n_state)
  );

  // Strobe bundle: pc_write, pc_write_cond, pc_write_ncond, iord, mem_read,
  // mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
  // alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
  logic [16:0] h_sv, n_sv;
  assign h_sv = {h_pw, h_pwc, h_pwn, h_iord, h_mr, h_mw, h_irw, h_m2r, h_rw, h_rd, h_sa, h_sb, h_op, h_ps};
  assign n_sv = {n_pw, n_pwc, n_pwn, n_iord, n_mr, n_mw, n_irw, n_m2r, n_rw, n_rd, n_sa, n_sb, n_op, n_ps};

  localparam logic [16:0] V_0    = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_FW   = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] V_FR   = 17'b1_0_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [16:0] V_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] V_MADR = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [16:0] V_MRD  = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MWB  = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [16:0] V_MWR  = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_EX   = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [16:0] V_AWB  = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [16:0] V_BEQ  = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] V_BNE  = 17'b0_0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] V_J    = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [16:0] V_IWB  = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_00;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

  // Stimulus only: one reset cycle, returns at the negedge where rst drops.
  task automatic apply_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    @(negedge clk);
    #1;
    n_chk++;
    if ({h_state, h_sv, h_fault} !== {4'd0, V_0, 1'b0})
      $display("FAIL reset_held: got st=%0d sb=%b f=%b exp st=0 sb=%b f=0", h_state, h_sv, h_fault, V_0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({h_state, h_sv, h_fault} !== {4'd0, V_FR, 1'b0})
      $display("FAIL reset_release: got st=%0d sb=%b f=%b exp st=0 sb=%b f=0", h_state, h_sv, h_fault, V_FR);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [3:0]  es[5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [16:0] ev[5] = '{V_FR, V_DEC, V_EX, V_AWB, V_FR};
    apply_rst();
    opcode = OP_R; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if ({h_state, h_sv, h_fault} !== {es[i], ev[i], 1'b0})
        $display("FAIL rtype cyc%0d: got st=%0d sb=%b f=%b exp st=%0d sb=%b f=0", i+1, h_state, h_sv, h_fault, es[i], ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic        rd[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  es[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [16:0] ev[9] = '{V_FR, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MRD, V_MWB, V_FR};
    apply_rst();
    opcode = OP_LW;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      n_chk++;
      if ({h_state, h_sv, h_fault} !== {es[i], ev[i], 1'b0})
        $display("FAIL lw_wait cyc%0d: got st=%0d sb=%b f=%b exp st=%0d sb=%b f=0", i+1, h_state, h_sv, h_fault, es[i], ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout();
    int bad = 0;
    apply_rst();
    opcode = OP_R; mem_ready = 1'b0;
    // 16 stalled FETCH cycles are tolerated
    for (int i = 0; i < 16; i++) begin
      #1;
      if ({h_state, h_sv, h_fault} !== {4'd0, V_FW, 1'b0}) begin
        if (bad == 0)
          $display("FAIL timeout_stall cyc%0d: got st=%0d sb=%b f=%b exp st=0 sb=%b f=0", i+1, h_state, h_sv, h_fault, V_FW);
        bad++;
      end
      @(negedge clk);
    end
    n_chk++;
    if (bad == 0) n_pass++;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if ({h_state, h_sv, h_fault} !== {4'd12, V_0, 1'b1})
        $display("FAIL timeout_fault cyc%0d: got st=%0d sb=%b f=%b exp st=12 sb=%b f=1", i+17, h_state, h_sv, h_fault, V_0);
      else n_pass++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    apply_rst();
    #1;
    n_chk++;
    if ({h_state, h_sv, h_fault} !== {4'd0, V_FW, 1'b0})
      $display("FAIL timeout_clear: got st=%0d sb=%b f=%b exp st=0 sb=%b f=0", h_state, h_sv, h_fault, V_FW);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd12, 4'd12};
    logic [16:0] ev[4] = '{V_FR, V_DEC, V_0, V_0};
    logic        ef[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_rst();
    opcode = OP_BAD; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if ({h_state, h_sv, h_fault} !== {es[i], ev[i], ef[i]})
        $display("FAIL illegal cyc%0d: got st=%0d sb=%b f=%b exp st=%0d sb=%b f=%b", i+1, h_state, h_sv, h_fault, es[i], ev[i], ef[i]);
      else n_pass++;
      @(negedge clk);
    end
    opcode = OP_R;
    apply_rst();
    #1;
    n_chk++;
    if ({h_state, h_fault} !== {4'd0, 1'b0})
      $display("FAIL illegal_rst: got st=%0d f=%b exp st=0 f=0", h_state, h_fault);
    else n_pass++;
    @(negedge clk);
  endtask

  // bne, beq, j back to back; opcode is changed in BRANCH/JUMP to show it is ignored there
  task automatic test_back_to_back();
    logic [5:0]  op[10] = '{OP_BNE, OP_BNE, OP_BEQ, OP_BEQ, OP_BEQ, OP_BNE, OP_J, OP_J, OP_BNE, OP_R};
    logic [3:0]  es[10] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
    logic [16:0] ev[10] = '{V_FR, V_DEC, V_BNE, V_FR, V_DEC, V_BEQ, V_FR, V_DEC, V_J, V_FR};
    apply_rst();
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      opcode = op[i];
      #1;
      n_chk++;
      if ({h_state, h_sv, h_fault} !== {es[i], ev[i], 1'b0})
        $display("FAIL back_to_back cyc%0d: got st=%0d sb=%b f=%b exp st=%0d sb=%b f=0", i+1, h_state, h_sv, h_fault, es[i], ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_addi();
    logic [5:0]  op[5] = '{OP_ADDI, OP_ADDI, OP_LW, OP_LW, OP_ADDI};
    logic [3:0]  es[5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    logic [16:0] ev[5] = '{V_FR, V_DEC, V_MADR, V_IWB, V_FR};
    apply_rst();
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = op[i];
      #1;
      n_chk++;
      if ({h_state, h_sv, h_fault} !== {es[i], ev[i], 1'b0})
        $display("FAIL addi cyc%0d: got st=%0d sb=%b f=%b exp st=%0d sb=%b f=0", i+1, h_state, h_sv, h_fault, es[i], ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_sw_no_handshake();
    logic [3:0]  es[5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [16:0] ev[5] = '{V_FR, V_DEC, V_MADR, V_MWR, V_FR};
    mem_ready_nh = 1'b0;
    apply_rst();
    opcode = OP_SW;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if ({n_state, n_sv, n_fault} !== {es[i], ev[i], 1'b0})
        $display("FAIL sw_nohs cyc%0d: got st=%0d sb=%b f=%b exp st=%0d sb=%b f=0", i+1, n_state, n_sv, n_fault, es[i], ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_rtype();
    test_lw_wait();
    test_fetch_timeout();
    test_illegal();
    test_back_to_back();
    test_addi();
    test_sw_no_handshake();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
